// File: rtl/writeback_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : writeback_scoreboard
// Brief    : Merges ALU and load results onto the single register-file write
//            port and keeps a busy scoreboard of pending destinations.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_scoreboard #(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter int ALU_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic            issue_wr,
    input  logic [4:0]      issue_rs1,
    input  logic [4:0]      issue_rs2,
    input  logic [4:0]      issue_rd,
    output logic            issue_stall,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_valid,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wdata,
    output logic [NREG-1:0] busy,
    output logic            sb_err
);

    localparam int c_PTR_W = (ALU_DEPTH > 1) ? $clog2(ALU_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(ALU_DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(ALU_DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(ALU_DEPTH - 1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

    // ALU result FIFO
    logic [4:0]         r_fifo_rd   [ALU_DEPTH];
    logic [XLEN-1:0]    r_fifo_data [ALU_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    // Write-port and scoreboard state
    logic               r_rf_we;
    logic [4:0]         r_rf_rd;
    logic [XLEN-1:0]    r_rf_wdata;
    logic [NREG-1:0]    r_busy;
    logic               r_sb_err;

    logic               w_fifo_empty;
    logic               w_fifo_full;
    logic               w_pop;
    logic               w_bypass;
    logic               w_alu_fire;
    logic               w_push;
    logic               w_sel_valid;
    logic [4:0]         w_sel_rd;
    logic [XLEN-1:0]    w_sel_data;
    logic               w_sel_write;
    logic               w_issue_acc;
    logic [NREG-1:0]    w_clr_mask;
    logic [NREG-1:0]    w_set_mask;
    logic [NREG-1:0]    w_busy_next;

    // ------------------------------------------------------------------
    // Handshake and arbitration: load beats FIFO head beats ALU bypass
    // ------------------------------------------------------------------
    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == c_DEPTH);
    assign w_pop        = ~ld_valid & ~w_fifo_empty;
    assign w_bypass     = ~ld_valid & w_fifo_empty & alu_valid;
    assign alu_ready    = ~w_fifo_full | w_pop;
    assign w_alu_fire   = alu_valid & alu_ready;
    assign w_push       = w_alu_fire & ~w_bypass;

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_rd    = 5'd0;
        w_sel_data  = '0;
        if (ld_valid) begin
            w_sel_valid = 1'b1;
            w_sel_rd    = ld_rd;
            w_sel_data  = ld_data;
        end else if (w_pop) begin
            w_sel_valid = 1'b1;
            w_sel_rd    = r_fifo_rd[r_rd_ptr];
            w_sel_data  = r_fifo_data[r_rd_ptr];
        end else if (w_bypass) begin
            w_sel_valid = 1'b1;
            w_sel_rd    = alu_rd;
            w_sel_data  = alu_data;
        end
    end

    // Results aimed at x0 still complete their handshake but never write.
    assign w_sel_write = w_sel_valid & (w_sel_rd != 5'd0);

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wr_ptr]   <= alu_rd;
            r_fifo_data[r_wr_ptr] <= alu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register-file write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rf_we    <= 1'b0;
            r_rf_rd    <= 5'd0;
            r_rf_wdata <= '0;
        end else begin
            r_rf_we <= w_sel_write;
            if (w_sel_write) begin
                r_rf_rd    <= w_sel_rd;
                r_rf_wdata <= w_sel_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard: clear on commit, set on accepted issue; set wins
    // ------------------------------------------------------------------
    assign issue_stall = r_busy[issue_rs1] | r_busy[issue_rs2] | (issue_wr & r_busy[issue_rd]);
    assign w_issue_acc = issue_valid & ~issue_stall & issue_wr & (issue_rd != 5'd0);

    always_comb begin
        w_clr_mask = '0;
        w_set_mask = '0;
        if (r_rf_we) begin
            w_clr_mask[r_rf_rd] = 1'b1;
        end
        if (w_issue_acc) begin
            w_set_mask[issue_rd] = 1'b1;
        end
        w_busy_next    = (r_busy & ~w_clr_mask) | w_set_mask;
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy   <= '0;
            r_sb_err <= 1'b0;
        end else begin
            r_busy   <= w_busy_next;
            r_sb_err <= r_sb_err | (r_rf_we & ~r_busy[r_rf_rd]);
        end
    end

    assign rf_we    = r_rf_we;
    assign rf_rd    = r_rf_rd;
    assign rf_wdata = r_rf_wdata;
    assign busy     = r_busy;
    assign sb_err   = r_sb_err;

endmodule
`default_nettype wire

// File: tb/tb_writeback_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_scoreboard
// Brief    : Scoreboard bench for writeback_scoreboard: directed scenarios
//            plus constrained-random issue/result traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_scoreboard;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            issue_valid, issue_wr;
    logic [4:0]      issue_rs1, issue_rs2, issue_rd;
    logic            issue_stall;
    logic            alu_valid, alu_ready;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            ld_valid;
    logic [4:0]      ld_rd;
    logic [XLEN-1:0] ld_data;
    logic            rf_we;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_wdata;
    logic [NREG-1:0] busy;
    logic            sb_err;

    always #5 clk = ~clk;

    writeback_scoreboard #(.XLEN(XLEN), .NREG(NREG), .ALU_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_rs1(issue_rs1),
        .issue_rs2(issue_rs2), .issue_rd(issue_rd), .issue_stall(issue_stall),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .busy(busy), .sb_err(sb_err)
    );

    typedef struct { logic we; logic [4:0] rd; logic [XLEN-1:0] data; } wb_t;
    typedef struct { logic [4:0] rd; logic [XLEN-1:0] data; } res_t;

    wb_t             exp_q[$];
    res_t            m_fifo[$];
    logic [4:0]      pend[$];
    logic [NREG-1:0] m_busy;
    logic            m_err, m_rf_we, m_issue_acc, obs_ready;
    logic [4:0]      m_rf_rd;
    logic [XLEN-1:0] m_rf_data;
    int              n_cmp = 0;
    int              n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: evaluated on settled inputs just before each active edge.
    task automatic model_eval();
        res_t            r;
        logic            sel, pop, rdy, stall, byp;
        logic [4:0]      srd;
        logic [XLEN-1:0] sdata;
        logic [NREG-1:0] nb;
        wb_t             e;
        #1;
        obs_ready   = alu_ready;
        m_issue_acc = 1'b0;
        if (reset) begin
            m_fifo.delete();
            m_busy    = '0;
            m_err     = 1'b0;
            m_rf_we   = 1'b0;
            m_rf_rd   = 5'd0;
            m_rf_data = '0;
        end else begin
            stall = m_busy[issue_rs1] | m_busy[issue_rs2] | (issue_wr & m_busy[issue_rd]);
            check("issue_stall", issue_stall, stall);
            pop = !ld_valid && (m_fifo.size() > 0);
            rdy = (m_fifo.size() < DEPTH) || pop;
            check("alu_ready", alu_ready, rdy);
            sel = 1'b0; byp = 1'b0; srd = 5'd0; sdata = '0;
            if (ld_valid) begin
                sel = 1'b1; srd = ld_rd; sdata = ld_data;
            end else if (pop) begin
                r = m_fifo.pop_front();
                sel = 1'b1; srd = r.rd; sdata = r.data;
            end else if (alu_valid) begin
                sel = 1'b1; byp = 1'b1; srd = alu_rd; sdata = alu_data;
            end
            if (alu_valid && rdy && !byp) m_fifo.push_back('{alu_rd, alu_data});
            nb = m_busy;
            if (m_rf_we) begin
                if (!m_busy[m_rf_rd]) m_err = 1'b1;
                nb[m_rf_rd] = 1'b0;
            end
            m_issue_acc = issue_valid && !stall && issue_wr && (issue_rd != 5'd0);
            if (m_issue_acc) nb[issue_rd] = 1'b1;
            m_busy  = nb;
            m_rf_we = sel && (srd != 5'd0);
            if (m_rf_we) begin
                m_rf_rd   = srd;
                m_rf_data = sdata;
            end
        end
        e.we = m_rf_we; e.rd = m_rf_rd; e.data = m_rf_data;
        exp_q.push_back(e);
    endtask

    task automatic monitor();
        wb_t e;
        check("exp_q_depth", 64'(exp_q.size()), 64'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check("rf_we", rf_we, e.we);
        check("rf_rd", rf_rd, e.rd);
        check("rf_wdata", rf_wdata, e.data);
        check("busy", busy, m_busy);
        check("sb_err", sb_err, m_err);
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        #1;
        monitor();
    endtask

    task automatic set_idle();
        issue_valid = 1'b0; issue_wr = 1'b0;
        issue_rs1 = 5'd0; issue_rs2 = 5'd0; issue_rd = 5'd0;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = '0;
        ld_valid  = 1'b0; ld_rd  = 5'd0; ld_data  = '0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [4:0] rs1);
        issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = rd; issue_rs1 = rs1; issue_rs2 = 5'd0;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [XLEN-1:0] d);
        alu_valid = 1'b1; alu_rd = rd; alu_data = d;
    endtask

    task automatic ld(input logic [4:0] rd, input logic [XLEN-1:0] d);
        ld_valid = 1'b1; ld_rd = rd; ld_data = d;
    endtask

    // Keep the current ALU result presented until it is accepted.
    task automatic alu_hold();
        int   k;
        logic fired;
        k = 0;
        fired = 1'b0;
        while (!fired && k < 16) begin
            tick();
            fired = alu_valid & obs_ready;
            k++;
        end
        check("alu_accept_timeout", fired, 1'b1);
        alu_valid = 1'b0;
    endtask

    initial begin
        set_idle();
        reset = 1'b1;
        tick();
        tick();
        check("rst_rf_rd", rf_rd, 5'd0);
        check("rst_rf_wdata", rf_wdata, 32'd0);
        reset = 1'b0;

        // Single ALU write-back with latency 1
        issue(5'd5, 5'd0); tick(); set_idle();
        alu(5'd5, 32'h11); tick(); set_idle();
        check("t1_we", rf_we, 1'b1);
        check("t1_rd", rf_rd, 5'd5);
        check("t1_data", rf_wdata, 32'h11);
        tick();
        check("t1_busy5_clear", busy[5], 1'b0);

        // RAW interlock on rs1 until the producer commits
        issue(5'd3, 5'd0); tick(); set_idle();
        issue(5'd4, 5'd3); tick();
        check("t2_stall", issue_stall, 1'b1);
        check("t2_busy4", busy[4], 1'b0);
        alu(5'd3, 32'h33); tick(); alu_valid = 1'b0;
        tick();
        #1;
        check("t2_unstall", issue_stall, 1'b0);
        set_idle(); tick();

        // Load beats ALU; ALU result queued and written next cycle
        issue(5'd7, 5'd0); tick();
        issue(5'd8, 5'd0); tick(); set_idle();
        ld(5'd7, 32'h77); alu(5'd8, 32'hAA); tick(); set_idle();
        check("t3_first_rd", rf_rd, 5'd7);
        tick();
        check("t3_second_rd", rf_rd, 5'd8);
        check("t3_second_data", rf_wdata, 32'hAA);
        tick();

        // Fill the FIFO behind three loads, then drain in ALU order
        for (int i = 0; i < 6; i++) begin
            issue(5'(10 + i), 5'd0); tick();
        end
        set_idle();
        for (int i = 0; i < 3; i++) begin
            ld(5'(13 + i), 32'h100 + i);
            alu(5'(10 + i), 32'hA0 + i);
            tick();
        end
        check("t4_ready_full", obs_ready, 1'b0);
        ld_valid = 1'b0;
        alu_hold();
        check("t4_head_rd", rf_rd, 5'd10);
        tick();
        check("t4_mid_rd", rf_rd, 5'd11);
        tick();
        check("t4_tail_rd", rf_rd, 5'd12);
        check("t4_tail_data", rf_wdata, 32'hA2);
        tick(); tick();

        // Result to x0: consumed, never written
        alu(5'd0, 32'hFFFF); tick(); set_idle();
        check("t5_ready", obs_ready, 1'b1);
        check("t5_we", rf_we, 1'b0);
        check("t5_busy", busy, 32'd0);
        tick();

        // Random issue/result traffic on x16..x31
        for (int c = 0; c < 80; c++) begin
            issue_valid = 1'($urandom_range(0, 1));
            issue_wr    = ($urandom_range(0, 3) != 0);
            issue_rd    = 5'($urandom_range(16, 31));
            issue_rs1   = 5'($urandom_range(0, 31));
            issue_rs2   = 5'($urandom_range(0, 31));
            if (!alu_valid && pend.size() > 0 && $urandom_range(0, 1) == 1) begin
                alu_valid = 1'b1; alu_rd = pend.pop_front(); alu_data = $urandom;
            end
            ld_valid = 1'b0;
            if (pend.size() > 0 && $urandom_range(0, 3) == 0) begin
                ld_valid = 1'b1; ld_rd = pend.pop_front(); ld_data = $urandom;
            end
            tick();
            if (alu_valid && obs_ready) alu_valid = 1'b0;
            if (m_issue_acc) pend.push_back(issue_rd);
        end
        issue_valid = 1'b0;
        for (int c = 0; c < 100 && (pend.size() > 0 || alu_valid); c++) begin
            ld_valid = 1'b0;
            if (pend.size() > 0) begin
                ld_valid = 1'b1; ld_rd = pend.pop_front(); ld_data = $urandom;
            end
            tick();
            if (alu_valid && obs_ready) alu_valid = 1'b0;
        end
        set_idle();
        tick(); tick(); tick();
        check("rnd_busy_drained", busy, 32'd0);

        // Write-back to a non-busy register raises a sticky error
        ld(5'd9, 32'h99); tick(); set_idle();
        check("t6_we", rf_we, 1'b1);
        tick();
        check("t6_err", sb_err, 1'b1);
        tick();
        check("t6_err_sticky", sb_err, 1'b1);

        // Reset while results sit in the FIFO
        issue(5'd20, 5'd0); tick();
        issue(5'd21, 5'd0); tick(); set_idle();
        ld(5'd9, 32'h9A); alu(5'd20, 32'h20); tick();
        ld(5'd9, 32'h9B); alu(5'd21, 32'h21); tick();
        set_idle();
        reset = 1'b1; tick(); reset = 1'b0;
        check("t6_rst_we", rf_we, 1'b0);
        check("t6_rst_busy", busy, 32'd0);
        check("t6_rst_err", sb_err, 1'b0);
        tick(); tick(); tick();
        check("t6_fifo_empty_ready", alu_ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
